// File: rtl/rw_ram_pkg.sv
// Shared constants for the rw_dual_port_ram storage primitive: FSM encodings,
// read-source select and the read-latency helper.
package rw_ram_pkg;

  localparam logic [0:0] StInit  = 1'b0;
  localparam logic [0:0] StReady = 1'b1;

  // Where the stage-1 read data comes from; SrcZero covers the window after reset.
  typedef enum logic [1:0] {
    SrcZero,
    SrcArray,
    SrcBypass,
    SrcInit
  } rd_src_e;

  function automatic int unsigned rd_lat(input int unsigned out_reg);
    return 1 + out_reg;
  endfunction

endpackage

// File: rtl/rw_ram_array.sv
// Plain storage array: one write port, one registered read port, no reset so
// it can map onto block RAM.
module rw_ram_array #(
  parameter int unsigned DATA_W = 4,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 2**ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Read-before-write inside the array; the top level supplies the bypass.
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/rw_dual_port_ram.sv
// Simple dual-port RAM with post-reset clear sequencer, write-first bypass,
// address range checking and an optional output register.
module rw_dual_port_ram
  import rw_ram_pkg::*;
#(
  parameter int unsigned       DATA_W   = 4,
  parameter int unsigned       ADDR_W   = 4,
  parameter int unsigned       DEPTH    = 2**ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0,
  parameter int unsigned       OUT_REG  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] datain,
  input  logic              read,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] dataout,
  output logic              rd_valid,
  output logic              busy,
  output logic              addr_err
);

  localparam int unsigned       RD_LAT  = rd_lat(OUT_REG);
  localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_cnt;

  logic              w_ready;
  logic              w_wr_in, w_rd_in;
  logic              w_wr_ok, w_rd_acc, w_rd_ok, w_err;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_arr_rdata;

  rd_src_e           r_src;
  logic [DATA_W-1:0] r_byp_data;
  logic              r_s1_vld, r_s1_err;
  logic [DATA_W-1:0] w_s1_data;

  assign w_ready  = (r_state == StReady);
  assign busy     = ~w_ready;
  assign w_wr_in  = {1'b0, wr_addr} < DEPTH_L;
  assign w_rd_in  = {1'b0, rd_addr} < DEPTH_L;
  assign w_wr_ok  = w_ready & write & w_wr_in;
  assign w_rd_acc = w_ready & read;
  assign w_rd_ok  = w_rd_acc & w_rd_in;
  assign w_err    = w_ready & ((write & ~w_wr_in) | (read & ~w_rd_in));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StInit;
      r_cnt   <= '0;
    end else if (r_state == StInit) begin
      if (r_cnt == LAST) r_state <= StReady;
      else               r_cnt   <= r_cnt + 1'b1;
    end
  end

  // The clear sequencer owns the write port until READY.
  assign w_we    = ~w_ready | w_wr_ok;
  assign w_waddr = w_ready ? wr_addr : r_cnt;
  assign w_wdata = w_ready ? datain  : INIT_VAL;

  rw_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .i_clk   (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rd_ok),
    .i_raddr (rd_addr),
    .o_rdata (w_arr_rdata)
  );

  // Source select only moves on an accepted read, so dataout holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src      <= SrcZero;
      r_byp_data <= '0;
      r_s1_vld   <= 1'b0;
      r_s1_err   <= 1'b0;
    end else begin
      r_s1_vld <= w_rd_acc;
      r_s1_err <= w_err;
      if (w_rd_acc) begin
        if (!w_rd_in) begin
          r_src <= SrcInit;
        end else if (w_wr_ok && (wr_addr == rd_addr)) begin
          r_src      <= SrcBypass;
          r_byp_data <= datain;
        end else begin
          r_src <= SrcArray;
        end
      end
    end
  end

  always_comb begin
    w_s1_data = '0;
    unique case (r_src)
      SrcZero:   w_s1_data = '0;
      SrcArray:  w_s1_data = w_arr_rdata;
      SrcBypass: w_s1_data = r_byp_data;
      SrcInit:   w_s1_data = INIT_VAL;
      default:   w_s1_data = '0;
    endcase
  end

  if (RD_LAT == 2) begin : g_out_reg
    logic [DATA_W-1:0] r_out_data;
    logic              r_out_vld, r_out_err;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_out_data <= '0;
        r_out_vld  <= 1'b0;
        r_out_err  <= 1'b0;
      end else begin
        r_out_vld <= r_s1_vld;
        r_out_err <= r_s1_err;
        if (r_s1_vld) r_out_data <= w_s1_data;
      end
    end

    assign dataout  = r_out_data;
    assign rd_valid = r_out_vld;
    assign addr_err = r_out_err;
  end else begin : g_no_out_reg
    assign dataout  = w_s1_data;
    assign rd_valid = r_s1_vld;
    assign addr_err = r_s1_err;
  end

endmodule

// File: doc/rw_dual_port_ram.md
# rw_dual_port_ram

Parametrised simple dual-port synchronous RAM: one write port and one independent read port on a single clock. It adds three things to the basic single-address read/write RAM: a hardware clear sequencer after reset, write-first bypass, and an optional output pipeline register. It is intended as the general storage primitive for buffer and lookup blocks in the design.

## Interface
- `DATA_W`, 4: word width in bits.
- `ADDR_W`, 4: address width in bits.
- `DEPTH`, 2**ADDR_W: number of words; legal range 2..2**ADDR_W.
- `INIT_VAL`, 0: value written to every word by the clear sequencer (DATA_W bits).
- `OUT_REG`, 0: 0 gives 1-cycle read latency; 1 adds an output register, giving 2-cycle latency.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `write`  in  1  write enable.
- `wr_addr`  in  ADDR_W  write address.
- `datain`  in  DATA_W  write data.
- `read`  in  1  read enable.
- `rd_addr`  in  ADDR_W  read address.
- `dataout`  out  DATA_W  read data; holds its value between reads.
- `rd_valid`  out  1  one-cycle pulse, aligned with new `dataout`.
- `busy`  out  1  high while the clear sequence runs.
- `addr_err`  out  1  one-cycle pulse for any accepted access with address ≥ DEPTH.

## Operation
- Two states: INIT and READY.
- Reset (rst_n low) forces the following immediately, without waiting for a clock edge:
  - state = INIT, clear counter = 0;
  - `busy` = 1;
  - `dataout` = 0, `rd_valid` = 0, `addr_err` = 0;
  - pipeline register = 0.
- INIT: each rising edge writes INIT_VAL to address `counter` and increments the counter. After the edge that writes address DEPTH-1, go to READY and drop `busy`.
- While in INIT, `read` and `write` are ignored: no memory change, no `rd_valid`, no `addr_err`.
- READY, write: `write` = 1 with `wr_addr` < DEPTH stores `datain` at `mem[wr_addr]`.
- READY, read: `read` = 1 with `rd_addr` < DEPTH returns `mem[rd_addr]`.
- Read and write in the same cycle:
  - different addresses: both complete independently;
  - same address: `dataout` returns the new `datain` (write-first bypass).
- Out-of-range access (address ≥ DEPTH, only possible when DEPTH < 2**ADDR_W):
  - write is dropped;
  - read returns INIT_VAL with `rd_valid` = 1;
  - `addr_err` pulses. If both ports are out of range in the same cycle, `addr_err` pulses once.
- With no read in a cycle, `dataout` holds its previous value and `rd_valid` is 0.
- Reset asserted mid-operation: any in-flight read is discarded and the full clear sequence runs again; earlier contents are not preserved.

## Timing
- Clear sequence takes DEPTH cycles. For the first rising edge after rst_n deasserts (edge 1), `busy` falls after edge DEPTH. The first access is accepted at edge DEPTH+1.
- Read latency, OUT_REG=0: a read sampled at edge N gives `dataout` and `rd_valid` valid after edge N, for one cycle.
- Read latency, OUT_REG=1: valid after edge N+1. `rd_valid` is pipelined with the data.
- Back-to-back reads on every cycle give one result per cycle; no bubbles.
- Write at edge N is visible to a read at edge N (bypass) and at every later edge.
- `addr_err` is registered with the same latency as `rd_valid`.
- rst_n deassertion must be synchronised externally to `clk`.

## Structure
- Shared package/header `rw_ram_pkg` holds:
  - state encodings (INIT=1'b0, READY=1'b1);
  - the latency localparam `RD_LAT = 1 + OUT_REG`.
- Sub-module `rw_ram_array`: plain storage array with one write port and one registered read port, no reset. This keeps the array mappable to block RAM.
- Top level holds the FSM, clear counter, bypass compare, range check and output pipeline.

## Test plan
- Default parameters. Release reset, no accesses → `busy` = 1 for exactly 16 cycles. Then reads of addresses 0x0..0xF each return 0x0 with `rd_valid` pulses.
- Write 0x6 to 0x3, then read 0x3 → `dataout` = 0x6 one cycle after the read edge, `rd_valid` high one cycle. Repeat with OUT_REG=1 → two cycles.
- Same edge: write 0xA to 0xA and read 0xA → `dataout` = 0xA (bypass). Same edge: write 0xF to 0x1 and read 0x2 → `dataout` = 0x0.
- During INIT: write 0xF to 0x1 and read 0x1 → no `rd_valid`. After READY, read 0x1 → 0x0.
- DEPTH=12 instance: write 0x5 to 0xD → `addr_err` pulse, memory unchanged. Then read 0xD → `dataout` = 0x0, `rd_valid` = 1, `addr_err` pulse.
- Write 0x4 to 0x2 and read it back. Drive rst_n low between clock edges → `dataout` = 0, `rd_valid` = 0, `busy` = 1 immediately. After the 16-cycle re-clear, read 0x2 → 0x0.
